// File: rtl/sar_search_4bit.sv
// Successive-approximation search engine. Drives the probe operand of an
// external magnitude comparator and uses its greater/less/equal flags to
// locate a hidden WIDTH-bit value by binary search, one compare per cycle.
module sar_search_4bit #(
   parameter int WIDTH = 4,
   parameter int SW    = $clog2(WIDTH + 2)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             greater,
   input  logic             less,
   input  logic             equal,
   output logic [WIDTH-1:0] probe,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [WIDTH-1:0] result,
   output logic [SW-1:0]    steps
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SEARCH = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   localparam logic [WIDTH-1:0] RANGE_MAX  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] PROBE_INIT = {1'b0, {(WIDTH-1){1'b1}}};

   logic [1:0]       state_q,  state_d;
   logic [WIDTH-1:0] probe_q,  probe_d;
   logic [WIDTH-1:0] lo_q,     lo_d;
   logic [WIDTH-1:0] hi_q,     hi_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [SW-1:0]    steps_q,  steps_d;
   logic             error_q,  error_d;
   logic             onehot;

   // Exactly one comparator flag must be set for a compare to be trusted.
   always_comb begin
      onehot = (greater ^ less ^ equal) & ~(greater & less & equal);
   end

   // Next-state logic: load bounds on start, narrow them on every compare.
   always_comb begin
      state_d  = state_q;
      probe_d  = probe_q;
      lo_d     = lo_q;
      hi_d     = hi_q;
      result_d = result_q;
      steps_d  = steps_q;
      error_d  = error_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SEARCH;
               lo_d    = '0;
               hi_d    = RANGE_MAX;
               probe_d = PROBE_INIT;
               steps_d = '0;
               error_d = 1'b0;
            end
         end
         S_SEARCH: begin
            steps_d = steps_q + SW'(1);
            if (!onehot) begin
               error_d  = 1'b1;
               result_d = probe_q;
               state_d  = S_DONE;
            end else if (equal) begin
               error_d  = 1'b0;
               result_d = probe_q;
               state_d  = S_DONE;
            end else if (greater) begin
               // Hidden value above probe: a probe already at hi means the
               // bounds would cross, so the comparator is inconsistent.
               if (probe_q == hi_q) begin
                  error_d  = 1'b1;
                  result_d = probe_q;
                  state_d  = S_DONE;
               end else begin
                  lo_d    = probe_q + WIDTH'(1);
                  probe_d = WIDTH'(({1'b0, probe_q} + {1'b0, hi_q}
                                    + (WIDTH+1)'(1)) >> 1);
               end
            end else begin
               // Hidden value below probe; symmetric crossing check at lo.
               if (probe_q == lo_q) begin
                  error_d  = 1'b1;
                  result_d = probe_q;
                  state_d  = S_DONE;
               end else begin
                  hi_d    = probe_q - WIDTH'(1);
                  probe_d = WIDTH'(({1'b0, lo_q} + {1'b0, probe_q}
                                    - (WIDTH+1)'(1)) >> 1);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset clears everything, including mid-search.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         probe_q  <= '0;
         lo_q     <= '0;
         hi_q     <= '0;
         result_q <= '0;
         steps_q  <= '0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         probe_q  <= probe_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         result_q <= result_d;
         steps_q  <= steps_d;
         error_q  <= error_d;
      end
   end

   assign probe  = probe_q;
   assign busy   = (state_q != S_IDLE);
   assign done   = (state_q == S_DONE);
   assign error  = error_q;
   assign result = result_q;
   assign steps  = steps_q;

endmodule

// File: tb/tb_sar_search_4bit.sv
// Directed bench for sar_search_4bit: a behavioural comparator answers the
// probe, table vectors cover normal searches, hand sequences cover faults.
module tb_sar_search_4bit;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       greater, less, equal;
   logic [3:0] probe;
   logic       busy, done, error;
   logic [3:0] result;
   logic [2:0] steps;

   logic [3:0] hid;
   int         mode;   // 0: real comparator, 1: all flags low, 2: greater stuck

   int n_chk  = 0;
   int n_fail = 0;
   int cyc;
   int nseen;
   logic [3:0] seen [0:7];

   typedef struct {
      logic [3:0]        a;
      int                n;
      bit [0:5][3:0]     seq;
   } vec_t;
   vec_t vecs [6];

   sar_search_4bit dut (
      .clk(clk), .reset(reset), .start(start),
      .greater(greater), .less(less), .equal(equal),
      .probe(probe), .busy(busy), .done(done), .error(error),
      .result(result), .steps(steps)
   );

   always #5 clk = ~clk;

   // Comparator sees hidden value on a, probe on b.
   always_comb begin
      greater = 1'b0;
      less    = 1'b0;
      equal   = 1'b0;
      case (mode)
         0: begin
            greater = (hid > probe);
            less    = (hid < probe);
            equal   = (hid == probe);
         end
         1: ;
         default: greater = 1'b1;
      endcase
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Pulse start (optionally held through SEARCH) and stop in the DONE cycle.
   task automatic do_search(input bit hold_start);
      start = 1'b1;
      tick();
      if (!hold_start) start = 1'b0;
      cyc   = 1;
      nseen = 0;
      while (!done && cyc < 20) begin
         if (nseen < 8) seen[nseen] = probe;
         nseen++;
         tick();
         cyc++;
      end
      chk("done_reached", done, 1);
   endtask

   initial begin
      vecs[0] = '{a: 4'd7,  n: 1, seq: {4'd7, 4'd0,  4'd0,  4'd0,  4'd0,  4'd0}};
      vecs[1] = '{a: 4'd15, n: 5, seq: {4'd7, 4'd11, 4'd13, 4'd14, 4'd15, 4'd0}};
      vecs[2] = '{a: 4'd0,  n: 4, seq: {4'd7, 4'd3,  4'd1,  4'd0,  4'd0,  4'd0}};
      vecs[3] = '{a: 4'd4,  n: 4, seq: {4'd7, 4'd3,  4'd5,  4'd4,  4'd0,  4'd0}};
      vecs[4] = '{a: 4'd8,  n: 4, seq: {4'd7, 4'd11, 4'd9,  4'd8,  4'd0,  4'd0}};
      vecs[5] = '{a: 4'd12, n: 4, seq: {4'd7, 4'd11, 4'd13, 4'd12, 4'd0,  4'd0}};

      mode  = 0;
      hid   = 4'd0;
      reset = 1'b1;
      start = 1'b1;   // must be dropped while reset is high
      tick();
      tick();
      chk("rst_probe", probe, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_result", result, 0);
      chk("rst_steps", steps, 0);
      reset = 1'b0;
      start = 1'b0;
      tick();
      chk("idle_busy", busy, 0);

      // First-cycle timing: probe 7 and busy the cycle after start.
      hid   = 4'd9;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("c1_probe", probe, 7);
      chk("c1_busy", busy, 1);
      while (busy && cyc < 30) begin tick(); cyc++; end
      cyc = 0;

      // Table-driven searches with a consistent comparator.
      for (int i = 0; i < 6; i++) begin
         hid = vecs[i].a;
         do_search(1'b0);
         chk($sformatf("done_cycle_a%0d", vecs[i].a), cyc, vecs[i].n + 1);
         chk($sformatf("nprobes_a%0d", vecs[i].a), nseen, vecs[i].n);
         for (int j = 0; j < vecs[i].n && j < 6; j++)
            chk($sformatf("probe_a%0d_%0d", vecs[i].a, j), seen[j], vecs[i].seq[j]);
         chk($sformatf("result_a%0d", vecs[i].a), result, vecs[i].a);
         chk($sformatf("steps_a%0d", vecs[i].a), steps, vecs[i].n);
         chk($sformatf("error_a%0d", vecs[i].a), error, 0);
         chk("done_busy", busy, 1);
         tick();
         chk("post_done", done, 0);
         chk("post_busy", busy, 0);
         chk("post_result_hold", result, vecs[i].a);
      end

      // Sweep every hidden value.
      for (int a = 0; a < 16; a++) begin
         hid = 4'(a);
         do_search(1'b0);
         chk($sformatf("sweep_result_%0d", a), result, a);
         chk($sformatf("sweep_steps_le5_%0d", a), (steps <= 3'd5) ? 1 : 0, 1);
         chk($sformatf("sweep_steps_vs_cycle_%0d", a), steps, cyc - 1);
         chk($sformatf("sweep_error_%0d", a), error, 0);
         tick();
      end

      // All flags low in the first SEARCH cycle.
      mode = 1;
      do_search(1'b0);
      mode = 0;
      chk("zero_done_cycle", cyc, 2);
      chk("zero_error", error, 1);
      chk("zero_result", result, 7);
      chk("zero_steps", steps, 1);
      tick();
      chk("zero_error_hold", error, 1);
      hid = 4'd4;
      do_search(1'b0);
      chk("after_err_error", error, 0);
      chk("after_err_result", result, 4);
      tick();

      // greater stuck high: walks to 15 then bounds would cross.
      mode = 2;
      do_search(1'b0);
      mode = 0;
      chk("stuck_done_cycle", cyc, 6);
      chk("stuck_probe3", seen[3], 14);
      chk("stuck_probe4", seen[4], 15);
      chk("stuck_error", error, 1);
      chk("stuck_result", result, 15);
      chk("stuck_steps", steps, 5);
      tick();

      // start held high through SEARCH and DONE is ignored.
      hid = 4'd15;
      do_search(1'b1);
      chk("hold_done_cycle", cyc, 6);
      chk("hold_steps", steps, 5);
      chk("hold_result", result, 15);
      tick();   // start still high in DONE: no new search queued
      start = 1'b0;
      chk("hold_idle_busy", busy, 0);
      tick();
      chk("hold_idle_busy2", busy, 0);

      // Reset during cycle 3 of an a=15 search.
      hid   = 4'd15;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("mid_probe_c3", probe, 13);
      reset = 1'b1;
      tick();
      chk("mid_rst_probe", probe, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_error", error, 0);
      chk("mid_rst_result", result, 0);
      chk("mid_rst_steps", steps, 0);
      start = 1'b1;   // dropped: same cycle as reset
      tick();
      reset = 1'b0;
      start = 1'b0;
      chk("rst_start_dropped", busy, 0);
      tick();
      chk("rst_start_dropped2", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
